// File: rtl/avalon_pwm_multi_pkg.sv
// Shared register map and bit positions for the multi-channel Avalon PWM block.
package avalon_pwm_multi_pkg;

    localparam int unsigned ADDR_CTRL      = 0;
    localparam int unsigned ADDR_PERIOD    = 1;
    localparam int unsigned ADDR_PRESCALE  = 2;
    localparam int unsigned ADDR_POL       = 3;
    localparam int unsigned ADDR_STATUS    = 4;
    localparam int unsigned ADDR_DUTY_BASE = 8;

    localparam int unsigned CTRL_GLOB_EN_BIT = 0;
    localparam int unsigned CTRL_CH_EN_LSB   = 1;

    localparam int unsigned STATUS_WRAP_BIT = 16;

endpackage

// File: rtl/avalon_pwm_multi_if.sv
// Avalon-MM slave bus bundle (zero read latency, no waitrequest).
interface avalon_pwm_multi_if #(
    parameter int unsigned ADDR_W = 4
);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_pwm_multi_pwm_channel.sv
// One PWM channel: pending duty register, period-boundary duty shadow and output flop.
module avalon_pwm_multi_pwm_channel #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             duty_we_i,
    input  logic [CNT_W:0]   duty_wdata_i,
    input  logic             load_sh_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W:0]   duty_o,
    output logic             pwm_o
);

    logic [CNT_W:0] duty_q, duty_d;
    logic [CNT_W:0] duty_sh_q, duty_sh_d;
    logic           pwm_q, pwm_d;
    logic           raw;

    always_comb begin
        duty_d    = duty_we_i ? duty_wdata_i : duty_q;
        // Shadow takes the pre-write value, so a write on a wrap cycle waits a period.
        duty_sh_d = load_sh_i ? duty_q : duty_sh_q;
        raw       = {1'b0, cnt_i} < duty_sh_q;
        pwm_d     = (en_i & raw) ^ pol_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q    <= '0;
            duty_sh_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            duty_q    <= duty_d;
            duty_sh_q <= duty_sh_d;
            pwm_q     <= pwm_d;
        end
    end

    assign duty_o = duty_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM with shared prescaler/period counter and an Avalon-MM register slave.
module avalon_pwm_multi
    import avalon_pwm_multi_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PRE_W  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    avalon_pwm_multi_if.slave   bus,
    output logic [NUM_CH-1:0]   pwm_out
);

    logic [NUM_CH:0]    ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   period_sh_q, period_sh_d;
    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic [NUM_CH-1:0]  pol_q, pol_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wrap_flag_q, wrap_flag_d;

    logic               wr;
    logic               glob_en;
    logic [NUM_CH-1:0]  ch_en;
    logic               tick;
    logic               wrap;
    logic               load_sh;
    logic [NUM_CH-1:0]  duty_we;
    logic [CNT_W:0]     duty_rd [NUM_CH];
    logic               unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign glob_en      = ctrl_q[CTRL_GLOB_EN_BIT];
    assign ch_en        = ctrl_q[CTRL_CH_EN_LSB +: NUM_CH];
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        tick    = glob_en && (pre_cnt_q == prescale_q);
        wrap    = tick && (cnt_q == period_sh_q);
        load_sh = wrap | ~glob_en;

        // Running past a lowered PRESCALE simply wraps the counter at all-ones.
        if (!glob_en || tick) pre_cnt_d = '0;
        else                  pre_cnt_d = pre_cnt_q + PRE_W'(1);

        if (!glob_en || wrap) cnt_d = '0;
        else if (tick)        cnt_d = cnt_q + CNT_W'(1);
        else                  cnt_d = cnt_q;

        period_sh_d = load_sh ? period_q : period_sh_q;
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        period_d    = period_q;
        prescale_d  = prescale_q;
        pol_d       = pol_q;
        wrap_flag_d = wrap_flag_q;
        if (wr) begin
            case (bus.address)
                ADDR_W'(ADDR_CTRL):     ctrl_d      = bus.writedata[NUM_CH:0];
                ADDR_W'(ADDR_PERIOD):   period_d    = bus.writedata[CNT_W-1:0];
                ADDR_W'(ADDR_PRESCALE): prescale_d  = bus.writedata[PRE_W-1:0];
                ADDR_W'(ADDR_POL):      pol_d       = bus.writedata[NUM_CH-1:0];
                ADDR_W'(ADDR_STATUS):   wrap_flag_d = 1'b0;
                default: ;
            endcase
        end
        // A wrap coinciding with the clearing write keeps the flag set.
        if (wrap) wrap_flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            period_q    <= '1;
            period_sh_q <= '0;
            prescale_q  <= '0;
            pol_q       <= '0;
            pre_cnt_q   <= '0;
            cnt_q       <= '0;
            wrap_flag_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            period_sh_q <= period_sh_d;
            prescale_q  <= prescale_d;
            pol_q       <= pol_d;
            pre_cnt_q   <= pre_cnt_d;
            cnt_q       <= cnt_d;
            wrap_flag_q <= wrap_flag_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign duty_we[i] = wr && (bus.address == ADDR_W'(ADDR_DUTY_BASE + i));

        avalon_pwm_multi_pwm_channel #(
            .CNT_W (CNT_W)
        ) u_pwm_channel (
            .clk          (clk),
            .reset        (reset),
            .duty_we_i    (duty_we[i]),
            .duty_wdata_i (bus.writedata[CNT_W:0]),
            .load_sh_i    (load_sh),
            .en_i         (glob_en & ch_en[i]),
            .pol_i        (pol_q[i]),
            .cnt_i        (cnt_q),
            .duty_o       (duty_rd[i]),
            .pwm_o        (pwm_out[i])
        );
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_W'(ADDR_CTRL):     bus.readdata[NUM_CH:0]  = ctrl_q;
            ADDR_W'(ADDR_PERIOD):   bus.readdata[CNT_W-1:0] = period_q;
            ADDR_W'(ADDR_PRESCALE): bus.readdata[PRE_W-1:0] = prescale_q;
            ADDR_W'(ADDR_POL):      bus.readdata[NUM_CH-1:0] = pol_q;
            ADDR_W'(ADDR_STATUS): begin
                bus.readdata[CNT_W-1:0]       = cnt_q;
                bus.readdata[STATUS_WRAP_BIT] = wrap_flag_q;
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.address == ADDR_W'(ADDR_DUTY_BASE + i)) bus.readdata[CNT_W:0] = duty_rd[i];
        end
    end

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Self-checking bench: register table, fixed and random PWM configs against an arithmetic model.
module tb_avalon_pwm_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pwm_out;

    avalon_pwm_multi_if #(.ADDR_W(4)) bus ();

    avalon_pwm_multi #(
        .NUM_CH (4),
        .CNT_W  (8),
        .PRE_W  (16),
        .ADDR_W (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        int         pre;
        int         per;
        logic [3:0] pol;
        logic [3:0] chen;
        int         duty [4];
    } cfg_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: duty per channel per period index since enable.
    int         m_pre;
    int         m_per;
    logic [3:0] m_pol;
    logic [3:0] m_chen;
    int         m_duty [4][8];

    reg_vec_t rv [16];
    cfg_t     ct [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    function automatic cfg_t mk_cfg(input int pre, input int per, input logic [3:0] pol,
                                    input logic [3:0] chen, input int d0, input int d1,
                                    input int d2, input int d3);
        cfg_t c;
        c.pre = pre; c.per = per; c.pol = pol; c.chen = chen;
        c.duty[0] = d0; c.duty[1] = d1; c.duty[2] = d2; c.duty[3] = d3;
        return c;
    endfunction

    // j = sample index, counted from the first negedge after the enabling write.
    function automatic logic [3:0] model_pwm(input int j);
        logic [3:0] r;
        int k, c, p;
        if (j == 0) return m_pol;
        k = j - 1;
        c = (k / (m_pre + 1)) % (m_per + 1);
        p = k / ((m_pre + 1) * (m_per + 1));
        if (p > 7) p = 7;
        for (int ch = 0; ch < 4; ch++) r[ch] = (m_chen[ch] && (c < m_duty[ch][p])) ^ m_pol[ch];
        return r;
    endfunction

    function automatic logic [31:0] model_status(input int j);
        logic [31:0] s;
        int c;
        s = '0;
        c = (j / (m_pre + 1)) % (m_per + 1);
        s[7:0] = c[7:0];
        s[16]  = (j >= (m_pre + 1) * (m_per + 1));
        return s;
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic do_reset();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_cfg(input cfg_t c);
        do_reset();
        do_write(4'd1, 32'(c.per));
        do_write(4'd2, 32'(c.pre));
        do_write(4'd3, 32'(c.pol));
        for (int i = 0; i < 4; i++) do_write(4'(8 + i), 32'(c.duty[i]));
        m_pre  = c.pre;
        m_per  = c.per;
        m_pol  = c.pol;
        m_chen = c.chen;
        for (int i = 0; i < 4; i++)
            for (int p = 0; p < 8; p++) m_duty[i][p] = c.duty[i];
        do_write(4'd0, {27'b0, c.chen, 1'b1});
        bus.address = 4'd4;
    endtask

    task automatic run_check(input string tag, input int ncyc);
        for (int j = 0; j < ncyc; j++) begin
            #1;
            chk($sformatf("%s pwm j=%0d", tag, j), 32'(pwm_out), 32'(model_pwm(j)));
            chk($sformatf("%s status j=%0d", tag, j), bus.readdata, model_status(j));
            @(negedge clk);
        end
    endtask

    // Stop, confirm the sticky wrap flag survives, then clear it with a STATUS write.
    task automatic sticky_check(input string tag);
        do_write(4'd0, 32'h0);
        bus.address = 4'd4;
        @(negedge clk);
        #1;
        chk({tag, " sticky held"}, bus.readdata, 32'h0001_0000);
        do_write(4'd4, 32'h0);
        #1;
        chk({tag, " sticky cleared"}, bus.readdata, 32'h0);
    endtask

    initial begin
        bus.address    = '0;
        bus.writedata  = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset pwm_out", 32'(pwm_out), 32'h0);

        rv[0]  = '{1'b0, 4'd0,  32'h0,         32'h0};
        rv[1]  = '{1'b0, 4'd1,  32'h0,         32'hFF};
        rv[2]  = '{1'b0, 4'd2,  32'h0,         32'h0};
        rv[3]  = '{1'b0, 4'd3,  32'h0,         32'h0};
        rv[4]  = '{1'b0, 4'd4,  32'h0,         32'h0};
        rv[5]  = '{1'b0, 4'd8,  32'h0,         32'h0};
        rv[6]  = '{1'b0, 4'd11, 32'h0,         32'h0};
        rv[7]  = '{1'b1, 4'd12, 32'hDEAD,      32'h0};
        rv[8]  = '{1'b1, 4'd1,  32'h1234,      32'h34};
        rv[9]  = '{1'b1, 4'd2,  32'h12345,     32'h2345};
        rv[10] = '{1'b1, 4'd3,  32'hFF,        32'hF};
        rv[11] = '{1'b1, 4'd8,  32'hFFFF,      32'h1FF};
        rv[12] = '{1'b1, 4'd11, 32'hAA,        32'hAA};
        rv[13] = '{1'b1, 4'd0,  32'h1E,        32'h1E};
        rv[14] = '{1'b1, 4'd7,  32'h55,        32'h0};
        rv[15] = '{1'b1, 4'd4,  32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 16; i++) begin
            if (rv[i].wr) do_write(rv[i].addr, rv[i].wdata);
            bus.address = rv[i].addr;
            #1;
            chk($sformatf("reg[%0d] addr %0d", i, rv[i].addr), bus.readdata, rv[i].exp);
        end
        // Channels enabled but glob_en off: every output sits at its POLARITY level.
        @(negedge clk);
        #1;
        chk("glob off pol level", 32'(pwm_out), 32'hF);
        @(negedge clk);

        ct[0] = mk_cfg(0, 9, 4'h0, 4'h1, 3, 0, 0, 0);
        ct[1] = mk_cfg(4, 3, 4'h0, 4'h2, 0, 2, 0, 0);
        ct[2] = mk_cfg(0, 9, 4'h0, 4'h1, 0, 0, 0, 0);
        ct[3] = mk_cfg(0, 9, 4'h0, 4'h1, 10, 0, 0, 0);
        ct[4] = mk_cfg(0, 9, 4'h1, 4'h1, 0, 0, 0, 0);
        ct[5] = mk_cfg(0, 9, 4'h1, 4'h1, 10, 0, 0, 0);
        ct[6] = mk_cfg(0, 9, 4'h1, 4'h0, 3, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            start_cfg(ct[i]);
            run_check($sformatf("cfg%0d", i), 2 * (ct[i].pre + 1) * (ct[i].per + 1) + 4);
            sticky_check($sformatf("cfg%0d", i));
        end

        for (int r = 0; r < 8; r++) begin
            cfg_t c;
            int per;
            per = int'($urandom_range(1, 12));
            c = mk_cfg(int'($urandom_range(0, 3)), per, 4'($urandom), 4'($urandom),
                       int'($urandom_range(0, per + 2)), int'($urandom_range(0, per + 2)),
                       int'($urandom_range(0, per + 2)), int'($urandom_range(0, per + 2)));
            start_cfg(c);
            run_check($sformatf("rnd%0d", r), 2 * (c.pre + 1) * (c.per + 1) + 4);
        end

        // Mid-period duty write at cnt=5, then a write landing on the wrap cycle.
        start_cfg(mk_cfg(0, 9, 4'h0, 4'h1, 3, 0, 0, 0));
        m_duty[0][0] = 3; m_duty[0][1] = 7; m_duty[0][2] = 7;
        for (int p = 3; p < 8; p++) m_duty[0][p] = 5;
        for (int j = 0; j < 45; j++) begin
            #1;
            chk($sformatf("midwr pwm j=%0d", j), 32'(pwm_out), 32'(model_pwm(j)));
            if (j == 5 || j == 19) begin
                bus.address    = 4'd8;
                bus.writedata  = (j == 5) ? 32'd7 : 32'd5;
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
            end else begin
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b1;
            end
            @(negedge clk);
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;

        // Reset asserted while outputs are high.
        start_cfg(mk_cfg(0, 9, 4'h0, 4'hF, 5, 5, 5, 5));
        run_check("rstmid", 3);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid pwm", 32'(pwm_out), 32'h0);
        bus.address = 4'd0; #1; chk("rstmid ctrl", bus.readdata, 32'h0);
        bus.address = 4'd1; #1; chk("rstmid period", bus.readdata, 32'hFF);
        bus.address = 4'd8; #1; chk("rstmid duty0", bus.readdata, 32'h0);
        bus.address = 4'd4; #1; chk("rstmid status", bus.readdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid pwm after", 32'(pwm_out), 32'h0);

        // glob_en cleared mid-period: counter returns to 0, outputs to POLARITY.
        start_cfg(mk_cfg(0, 9, 4'b0101, 4'hF, 5, 5, 5, 5));
        run_check("gclr", 4);
        do_write(4'd0, 32'h1E);
        bus.address = 4'd4;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("gclr stop status %0d", j), bus.readdata, 32'h0);
            chk($sformatf("gclr stop pwm %0d", j), 32'(pwm_out), 32'h5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
